// File: rtl/bloom_hash_gen.sv
// Bloom-filter index generator: folds each element into two hashes, sets k
// double-hashed bits of a signature one per cycle, and accumulates inserts.
module bloom_hash_gen #(
    parameter int d_size  = 8,
    parameter int bl_size = 32,
    parameter int k_hash  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               op,
    input  logic [d_size-1:0]  data_in,
    input  logic               clear,
    output logic [bl_size-1:0] gen_bloom,
    output logic [bl_size-1:0] bloom_filter,
    output logic               check
);
    localparam int AW  = $clog2(bl_size);
    localparam int NCH = (d_size + AW - 1) / AW;
    localparam int PW  = NCH * AW;
    localparam int SW  = AW + 4;
    localparam logic [2:0] J_LAST = 3'(k_hash - 1);

    typedef enum logic [1:0] {IDLE, HASH, OUT} state_t;

    state_t             state_reg, state_next;
    logic [2:0]         j_reg, j_next;
    logic               op_reg, op_next;
    logic [AW-1:0]      h1_reg, h1_next;
    logic [AW-1:0]      h2_reg, h2_next;
    logic [bl_size-1:0] gen_bloom_reg, gen_bloom_next;
    logic [bl_size-1:0] bloom_filter_reg, bloom_filter_next;

    logic [d_size-1:0]       data_rev;
    logic [PW-1:0]           pad_fwd, pad_rev;
    logic [NCH:0][AW-1:0]    fold_fwd, fold_rev;
    logic [AW-1:0]           idx;
    logic [bl_size-1:0]      bit_sel;

    assign pad_fwd     = PW'(data_in);
    assign pad_rev     = PW'(data_rev);
    assign fold_fwd[0] = '0;
    assign fold_rev[0] = '0;

    generate
        genvar gi;
        for (gi = 0; gi < d_size; gi++) begin : g_rev
            assign data_rev[gi] = data_in[d_size-1-gi];
        end
        // XOR-fold of AW-bit chunks; the zero-extended top chunk may be partial
        for (gi = 0; gi < NCH; gi++) begin : g_fold
            assign fold_fwd[gi+1] = fold_fwd[gi] ^ pad_fwd[gi*AW +: AW];
            assign fold_rev[gi+1] = fold_rev[gi] ^ pad_rev[gi*AW +: AW];
        end
    endgenerate

    // Wide sum keeps the product exact before the mod-bl_size truncation
    assign idx     = AW'(SW'(h1_reg) + SW'(j_reg) * SW'(h2_reg));
    assign bit_sel = bl_size'(1) << idx;

    assign in_ready     = (state_reg == IDLE) && !clear && !rst;
    assign check        = (state_reg == OUT) && !op_reg;
    assign gen_bloom    = gen_bloom_reg;
    assign bloom_filter = bloom_filter_reg;

    always_comb begin
        state_next        = state_reg;
        j_next            = j_reg;
        op_next           = op_reg;
        h1_next           = h1_reg;
        h2_next           = h2_reg;
        gen_bloom_next    = gen_bloom_reg;
        bloom_filter_next = bloom_filter_reg;
        case (state_reg)
            IDLE: begin
                if (clear) begin
                    bloom_filter_next = '0;
                end else if (in_valid) begin
                    op_next        = op;
                    h1_next        = fold_fwd[NCH];
                    h2_next        = fold_rev[NCH] | AW'(1);
                    gen_bloom_next = '0;
                    j_next         = '0;
                    state_next     = HASH;
                end
            end
            HASH: begin
                gen_bloom_next = gen_bloom_reg | bit_sel;
                j_next         = j_reg + 3'd1;
                if (j_reg == J_LAST) begin
                    state_next = OUT;
                end
            end
            OUT: begin
                if (op_reg) begin
                    bloom_filter_next = bloom_filter_reg | gen_bloom_reg;
                end
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= IDLE;
            j_reg            <= '0;
            op_reg           <= 1'b0;
            h1_reg           <= '0;
            h2_reg           <= '0;
            gen_bloom_reg    <= '0;
            bloom_filter_reg <= '0;
        end else begin
            state_reg        <= state_next;
            j_reg            <= j_next;
            op_reg           <= op_next;
            h1_reg           <= h1_next;
            h2_reg           <= h2_next;
            gen_bloom_reg    <= gen_bloom_next;
            bloom_filter_reg <= bloom_filter_next;
        end
    end
endmodule

// File: tb/tb_bloom_hash_gen.sv
// Scoreboard bench for bloom_hash_gen: queries queue their expected signature
// and check cycle; a negedge monitor pops and compares on every check pulse.
module tb_bloom_hash_gen;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        op;
    logic [7:0]  data_in;
    logic        clear;
    logic [31:0] gen_bloom;
    logic [31:0] bloom_filter;
    logic        check;

    typedef struct {
        logic [31:0] gen;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    logic prev_check;

    bloom_hash_gen #(.d_size(8), .bl_size(32), .k_hash(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .data_in(data_in), .clear(clear), .gen_bloom(gen_bloom),
        .bloom_filter(bloom_filter), .check(check)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
        end else begin
            $display("ok   %s: %h (cycle %0d)", name, act, cyc);
        end
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            prev_check <= 1'b0;
        end else begin
            if (check) begin
                if (sb.size() == 0) begin
                    cmp("check_unexpected", 32'(check), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    cmp("query_gen_bloom", gen_bloom, mon_e.gen);
                    cmp("check_cycle", 32'(cyc), 32'(mon_e.cyc));
                end
                if (prev_check) cmp("check_width", {30'b0, prev_check, check}, 32'd1);
            end
            prev_check <= check;
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) cmp("ready_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic do_req(input logic o, input logic [7:0] d, input logic [31:0] exp_gen,
                          input logic [31:0] exp_filter, input logic clr_mid);
        logic busy_ok;
        wait_ready();
        in_valid = 1'b1;
        op       = o;
        data_in  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        data_in  = 8'($urandom);
        if (!o) sb.push_back('{exp_gen, cyc + 3});
        busy_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (in_ready) busy_ok = 1'b0;
            clear = clr_mid && (i == 0);
        end
        cmp("busy_in_ready_low", 32'(busy_ok), 32'd1);
        @(negedge clk);
        cmp("ready_after_out", 32'(in_ready), 32'd1);
        cmp("gen_bloom_held", gen_bloom, exp_gen);
        cmp("bloom_filter", bloom_filter, exp_filter);
    endtask

    initial begin
        int acc[$];
        int idle_cnt;
        rst = 1'b1; in_valid = 1'b0; op = 1'b0; data_in = 8'h00; clear = 1'b0;
        repeat (2) @(negedge clk);
        cmp("rst_in_ready", 32'(in_ready), 32'd0);
        cmp("rst_gen_bloom", gen_bloom, 32'd0);
        cmp("rst_filter", bloom_filter, 32'd0);
        cmp("rst_check", 32'(check), 32'd0);
        rst = 1'b0;
        #1;
        cmp("ready_after_rst", 32'(in_ready), 32'd1);

        do_req(1'b0, 8'h01, 32'h0000_0842, 32'h0000_0000, 1'b0);
        do_req(1'b1, 8'h01, 32'h0000_0842, 32'h0000_0842, 1'b0);
        do_req(1'b1, 8'h00, 32'h0000_0007, 32'h0000_0847, 1'b0);
        do_req(1'b0, 8'h01, 32'h0000_0842, 32'h0000_0847, 1'b0);
        cmp("query_subset", gen_bloom & ~bloom_filter, 32'd0);
        // clear pulsed mid-HASH must not touch the filter
        do_req(1'b0, 8'hFF, 32'h0102_0400, 32'h0000_0847, 1'b1);

        // clear wins over a simultaneous request in IDLE
        wait_ready();
        clear = 1'b1; in_valid = 1'b1; op = 1'b1; data_in = 8'h01;
        #1;
        cmp("clear_blocks_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        cmp("clear_empties", bloom_filter, 32'd0);
        @(negedge clk);
        clear = 1'b0;
        #1;
        cmp("not_accepted_on_clear", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        cmp("accepted_after_clear", bloom_filter, 32'h0000_0842);

        // back-to-back queries with in_valid held high
        wait_ready();
        in_valid = 1'b1; op = 1'b0; data_in = 8'h01;
        idle_cnt = 0;
        for (int n = 0; n < 16; n++) begin
            if (n > 0) @(negedge clk);
            if (n == 15) begin
                in_valid = 1'b0;
            end else if (in_ready) begin
                idle_cnt++;
                acc.push_back(cyc + 1);
                sb.push_back('{32'h0000_0842, cyc + 4});
            end
        end
        cmp("b2b_accepts", 32'(idle_cnt), 32'd3);
        if (acc.size() == 3) begin
            cmp("b2b_gap1", 32'(acc[1] - acc[0]), 32'd5);
            cmp("b2b_gap2", 32'(acc[2] - acc[1]), 32'd5);
        end
        wait_ready();

        // reset during HASH of an insert aborts it
        in_valid = 1'b1; op = 1'b1; data_in = 8'hFF;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        cmp("midrst_gen_bloom", gen_bloom, 32'd0);
        cmp("midrst_filter", bloom_filter, 32'd0);
        cmp("midrst_check", 32'(check), 32'd0);
        cmp("midrst_in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        cmp("ready_after_release", 32'(in_ready), 32'd1);
        repeat (8) @(negedge clk);
        cmp("filter_after_abort", bloom_filter, 32'd0);
        cmp("gen_after_abort", gen_bloom, 32'd0);

        repeat (2) @(negedge clk);
        cmp("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog expired");
    end
endmodule
